// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// State encoding, step-counter sizing and the divide-by-zero quotient pattern.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } div_state_e;

    localparam int DIV_MAX_WIDTH = 64;
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_i < divisor_i always holds, so the extra top bit of diff is a clean sign.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, Done pulse on completion.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int                 CNT_W     = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   QUOT_DZ   = DIV_ZERO_QUOT[WIDTH-1:0];

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dz_q, dz_d;
    logic             dz_pend_q, dz_pend_d;

`ifdef DIVIDER_SIGNED_EN
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] raw_quot;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // dvd_q doubles as the quotient shift register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quot_d    = quot_q;
        remd_d    = remd_q;
        dz_d      = dz_q;
        dz_pend_d = dz_pend_q;
`ifdef DIVIDER_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        raw_quot  = {dvd_q[WIDTH-2:0], step_qbit};

        unique case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    rem_d     = '0;
                    dz_d      = 1'b0;
                    dz_pend_d = (divisor_i == '0);
`ifdef DIVIDER_SIGNED_EN
                    dvd_d      = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
                    dvs_d      = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
                    neg_quot_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
                    neg_rem_d  = dividend_i[WIDTH-1];
`else
                    dvd_d = dividend_i;
                    dvs_d = divisor_i;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (dz_pend_q) begin
                    state_d   = ST_FIN;
                    dz_pend_d = 1'b0;
                    dz_d      = 1'b1;
                    quot_d    = QUOT_DZ;
`ifdef DIVIDER_SIGNED_EN
                    // Re-negating the magnitude restores the original dividend bits.
                    remd_d = neg_rem_q ? -dvd_q : dvd_q;
`else
                    remd_d = dvd_q;
`endif
                end else begin
                    rem_d = step_rem;
                    dvd_d = raw_quot;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FIN;
`ifdef DIVIDER_SIGNED_EN
                        quot_d = neg_quot_q ? -raw_quot : raw_quot;
                        remd_d = neg_rem_q  ? -step_rem : step_rem;
`else
                        quot_d = raw_quot;
                        remd_d = step_rem;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quot_q    <= '0;
            remd_q    <= '0;
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quot_q    <= quot_d;
            remd_q    <= remd_d;
            dz_q      <= dz_d;
            dz_pend_q <= dz_pend_d;
        end
    end

`ifdef DIVIDER_SIGNED_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end
`endif

    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_FIN);
    assign quotient_o  = quot_q;
    assign remainder_o = remd_q;
    assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=32): directed vector table, multi-cycle corner
// sequences and randomized operands against an arithmetic reference model.
module tb_seq_divider;

    logic        clk, rst, start;
    logic [31:0] dvd, dvs;
    logic        busy, done, dz;
    logic [31:0] quot, rem;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .dividend_i  (dvd),
        .divisor_i   (dvs),
        .busy_o      (busy),
        .done_o      (done),
        .quotient_o  (quot),
        .remainder_o (rem),
        .div_zero_o  (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands as the spec defines them.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            longint sa, sb;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
            z = 1'b0;
        end
    endfunction

    // Caller is at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        dvd   = a;
        dvs   = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dvd   = $urandom;
        dvs   = $urandom;
    endtask

    // Counts edges after accept until Done; lat=100 means it never arrived.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, bcnt, ndone;
        logic [31:0] eq, er;
        logic        ez;

        vecs.push_back('{"div_100_7",   32'd100,        32'd7,   32'd14,         32'd2,          1'b0, 32});
        vecs.push_back('{"div_7_100",   32'd7,          32'd100, 32'd0,          32'd7,          1'b0, 32});
        vecs.push_back('{"div_max_1",   32'hFFFF_FFFF,  32'd1,   32'hFFFF_FFFF,  32'd0,          1'b0, 32});
        vecs.push_back('{"div_zero",    32'hDEAD_BEEF,  32'd0,   32'hFFFF_FFFF,  32'hDEAD_BEEF,  1'b1, 1});
        vecs.push_back('{"div_9_3",     32'd9,          32'd3,   32'd3,          32'd0,          1'b0, 32});
`ifdef DIVIDER_SIGNED_EN
        vecs.push_back('{"sdiv_m7_2",   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32});
        vecs.push_back('{"sdiv_7_m2",   32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 32});
        vecs.push_back('{"sdiv_min_m1", 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 32});
`endif

        rst   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz",   {31'd0, dz},   32'd0);
        chk("rst_quot", quot, 32'd0);
        chk("rst_rem",  rem,  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            chk({vecs[i].name, "_dz_clear"}, {31'd0, dz}, 32'd0);
            wait_done(lat, bcnt);
            chk({vecs[i].name, "_lat"},  lat,  vecs[i].lat);
            chk({vecs[i].name, "_busy"}, bcnt, vecs[i].lat);
            chk({vecs[i].name, "_quot"}, quot, vecs[i].q);
            chk({vecs[i].name, "_rem"},  rem,  vecs[i].r);
            chk({vecs[i].name, "_dz"},   {31'd0, dz}, {31'd0, vecs[i].dz});
            @(negedge clk);
            chk({vecs[i].name, "_pulse"},   {31'd0, done}, 32'd0);
            chk({vecs[i].name, "_dz_hold"}, {31'd0, dz}, {31'd0, vecs[i].dz});
            chk({vecs[i].name, "_q_hold"},  quot, vecs[i].q);
        end

        // Start during RUN is ignored; Start during FIN is accepted back-to-back.
        issue(32'd1000, 32'd10);
        repeat (10) @(negedge clk);
        start = 1'b1;
        dvd   = 32'd50;
        dvs   = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("busy_ign_lat",  lat,  32'd21);
        chk("busy_ign_quot", quot, 32'd100);
        chk("busy_ign_rem",  rem,  32'd0);
        issue(32'd50, 32'd5);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, bcnt);
        chk("b2b_lat",  lat,  32'd32);
        chk("b2b_quot", quot, 32'd10);
        chk("b2b_rem",  rem,  32'd0);
        @(negedge clk);

        // Asynchronous reset between edges mid-operation.
        issue(32'd1000, 32'd10);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_quot", quot, 32'd0);
        chk("arst_rem",  rem,  32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("arst_no_done", ndone, 32'd0);
        issue(32'd81, 32'd9);
        wait_done(lat, bcnt);
        chk("post_rst_lat",  lat,  32'd32);
        chk("post_rst_quot", quot, 32'd9);
        chk("post_rst_rem",  rem,  32'd0);
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra, rb;
            int          sel;
            sel = $urandom_range(0, 9);
            ra  = (sel == 9) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
            if (sel == 0)      rb = 32'd0;
            else if (sel < 5)  rb = 32'($urandom_range(1, 255));
            else if (sel == 5) rb = 32'hFFFF_FFFF;
            else               rb = 32'($urandom);
            ref_div(ra, rb, eq, er, ez);
            issue(ra, rb);
            wait_done(lat, bcnt);
            chk("rand_lat",  lat,  ez ? 32'd1 : 32'd32);
            chk("rand_quot", quot, eq);
            chk("rand_rem",  rem,  er);
            chk("rand_dz",   {31'd0, dz}, {31'd0, ez});
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
